// File: rtl/clkdiv_glitchfree.sv
// ---------------------------------------------------------------------------
// clkdiv_glitchfree
//
// Programmable 50%-duty clock divider whose output flop drives the root of a
// clkbuf_16 distribution tree. Each half-period lasts DIV+1 CLK cycles.
// A new ratio is requested with LOAD. It is held pending and applied only at
// the rising-edge boundary of Y, or while idle. Enable and disable always
// complete full phases, so Y never produces a runt pulse. The one exception
// is the asynchronous reset R.
//
// Ports
//   CLK   in   source clock, rising edge
//   R     in   asynchronous reset, active high
//   EN    in   run request (level)
//   DIV   in   ratio code, captured on LOAD
//   LOAD  in   single-cycle request to adopt DIV
//   Y     out  divided clock, driven straight from a flop
//   ACK   out  one-cycle pulse when a pending ratio becomes active
//   BUSY  out  a loaded ratio is waiting to be applied
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | Y parked low, counter cleared, pending ratio applied at once
// RUN   | Y toggling; ratio changes and stop only at the rising boundary
// ---------------------------------------------------------------------------
module clkdiv_glitchfree #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             LOAD,
    output logic             Y,
    output logic             ACK,
    output logic             BUSY
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           st_q, st_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] div_p_q, div_p_d;
    logic             pend_q, pend_d;
    logic             y_q, y_d;
    logic             ack_q, ack_d;
    logic             at_bound;
    logic             apply;

    // The boundary is the edge at which Y would rise. It is the only point
    // in RUN where the phase length may change without cutting a phase short.
    assign at_bound = (st_q == RUN) && !y_q && (cnt_q == div_q);
    assign apply    = pend_q && ((st_q == IDLE) || at_bound);

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            st_q    <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            div_p_q <= '0;
            pend_q  <= 1'b0;
            y_q     <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            div_p_q <= div_p_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        div_p_d = div_p_q;
        pend_d  = pend_q;
        y_d     = y_q;
        ack_d   = 1'b0;

        // Applying the pending ratio takes precedence, so a start or restart
        // on this edge already runs its first high phase at the new ratio.
        if (apply) begin
            div_d  = div_p_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end

        case (st_q)
            IDLE: begin
                y_d   = 1'b0;
                cnt_d = '0;
                if (EN) begin
                    st_d = RUN;
                    y_d  = 1'b1;
                end
            end
            RUN: begin
                if (at_bound) begin
                    cnt_d = '0;
                    if (EN) begin
                        y_d = 1'b1;
                    end else begin
                        st_d = IDLE;
                        y_d  = 1'b0;
                    end
                end else if (cnt_q == div_q) begin
                    cnt_d = '0;
                    y_d   = ~y_q;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                st_d  = IDLE;
                y_d   = 1'b0;
                cnt_d = '0;
            end
        endcase

        // A LOAD on the applying edge is kept for the next boundary. The old
        // pending value has just been consumed, so the flag stays set.
        if (LOAD) begin
            div_p_d = DIV;
            pend_d  = 1'b1;
        end
    end

    assign Y    = y_q;
    assign ACK  = ack_q;
    assign BUSY = pend_q;

endmodule

// File: tb/tb_clkdiv_glitchfree.sv
// ---------------------------------------------------------------------------
// tb_clkdiv_glitchfree
//
// Scoreboard bench for clkdiv_glitchfree. The stimulus process drives the
// inputs. At each rising edge it advances a phase-level reference model,
// which tracks whether the divider is running, the current level, the cycles
// left in the current half-period and the active/pending ratio. It then
// queues the expected {Y, ACK, BUSY}. A separate monitor pops one entry on
// each falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_clkdiv_glitchfree;

    logic       CLK  = 1'b0;
    logic       R    = 1'b1;
    logic       EN   = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] DIV  = 4'd0;
    logic       Y, ACK, BUSY;

    clkdiv_glitchfree #(.WIDTH(4)) dut (
        .CLK  (CLK),
        .R    (R),
        .EN   (EN),
        .DIV  (DIV),
        .LOAD (LOAD),
        .Y    (Y),
        .ACK  (ACK),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic y;
        logic ack;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit m_run, m_y, m_pend, m_ack;
    int m_left, m_ratio, m_pval;

    function automatic void model_reset();
        m_run   = 0;
        m_y     = 0;
        m_pend  = 0;
        m_ack   = 0;
        m_left  = 0;
        m_ratio = 0;
        m_pval  = 0;
    endfunction

    function automatic void model_step(input bit en, input bit load, input int div);
        bit boundary;
        m_ack    = 0;
        boundary = m_run && !m_y && (m_left == 1);
        if ((!m_run || boundary) && m_pend) begin
            m_ratio = m_pval;
            m_pend  = 0;
            m_ack   = 1;
        end
        if (!m_run) begin
            if (en) begin
                m_run  = 1;
                m_y    = 1;
                m_left = m_ratio + 1;
            end
        end else if (boundary) begin
            if (en) begin
                m_y    = 1;
                m_left = m_ratio + 1;
            end else begin
                m_run = 0;
                m_y   = 0;
            end
        end else if (m_left == 1) begin
            m_y    = ~m_y;
            m_left = m_ratio + 1;
        end else begin
            m_left = m_left - 1;
        end
        if (load) begin
            m_pval = div;
            m_pend = 1;
        end
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit en, input bit load, input logic [3:0] div);
        exp_t e;
        EN   = en;
        LOAD = load;
        DIV  = div;
        @(posedge CLK);
        model_step(en, load, int'(div));
        e.y    = m_y;
        e.ack  = m_ack;
        e.busy = m_pend;
        exp_q.push_back(e);
        #1;
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("Y",    Y,    e.y);
                check("ACK",  ACK,  e.ack);
                check("BUSY", BUSY, e.busy);
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit found;
        bit en_mode;
        model_reset();
        R = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        R = 1'b0;
        #1;
        check("reset_Y",    Y,    1'b0);
        check("reset_ACK",  ACK,  1'b0);
        check("reset_BUSY", BUSY, 1'b0);

        // default ratio: period 2
        repeat (10) step(1, 0, 0);

        // async reset during a high phase
        @(negedge CLK);
        #1;
        found = m_y;
        for (int i = 0; i < 4 && !found; i++) begin
            step(1, 0, 0);
            @(negedge CLK);
            #1;
            found = m_y;
        end
        check("prereset_Y", Y, found);
        R  = 1'b1;
        EN = 1'b0;
        #1;
        check("async_rst_Y",    Y,    1'b0);
        check("async_rst_ACK",  ACK,  1'b0);
        check("async_rst_BUSY", BUSY, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        R = 1'b0;
        model_reset();
        #1;

        // LOAD DIV=3 while idle, then run at period 8
        step(0, 1, 3);
        repeat (3) step(0, 0, 0);
        repeat (24) step(1, 0, 0);

        // LOAD DIV=1 mid high phase
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0);
            found = m_y && (m_left == 2);
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_mid_high: got timeout expected high phase");
        end
        step(1, 1, 1);
        repeat (24) step(1, 0, 0);

        // two LOADs before the boundary, last one wins
        step(1, 1, 5);
        step(1, 1, 2);
        repeat (24) step(1, 0, 0);

        // EN dropped one cycle into a high phase at DIV=2
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1, 0, 0);
            found = m_y && (m_ratio == 2) && (m_left == 3) && !m_pend;
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_rise: got timeout expected rising edge at DIV=2");
        end
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        repeat (8) step(1, 0, 0);

        // widest ratio: period 32 over ten periods
        step(1, 1, 15);
        repeat (340) step(1, 0, 0);

        // randomized traffic
        en_mode = 1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) en_mode = ~en_mode;
            step(en_mode ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 11) == 0,
                 4'($urandom_range(0, 15)));
        end
        step(0, 0, 0);

        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_glitchfree.md
# clkdiv_glitchfree

Programmable, glitch-free clock divider that produces the registered root clock driving a clkbuf_16 distribution buffer. The divided clock always has a 50% duty cycle, and every pulse is full width. Ratio changes go through a LOAD/ACK handshake and take effect only at a phase boundary. Enable and disable never produce runt pulses.

## Interface
- WIDTH, 4: width of the ratio field. Half-period in CLK cycles is DIV+1, so the output period is 2*(DIV+1), from 2 to 2^(WIDTH+1).
- CLK  input  1  source clock; all state updates on the rising edge.
- R  input  1  asynchronous, active-high reset.
- EN  input  1  run request, level-sensitive.
- DIV  input  WIDTH  new ratio code, sampled only on a LOAD cycle.
- LOAD  input  1  single-cycle request to adopt DIV.
- Y  output  1  divided clock, a flop output. Drives the buffer's A pin directly with no combinational logic after the flop.
- ACK  output  1  one-cycle pulse in the cycle the new ratio becomes active.
- BUSY  output  1  high while a loaded ratio is pending and not yet applied.

## Operation
- Internal state:
  - cnt[WIDTH]: phase counter.
  - div_q[WIDTH]: active ratio.
  - div_p[WIDTH]: pending ratio.
  - pend: pending flag.
  - st: IDLE or RUN.
- Reset values: Y=0, ACK=0, BUSY=0, cnt=0, div_q=0 (divide-by-2), div_p=0, pend=0, st=IDLE.
- LOAD handling:
  - LOAD=1 captures div_p<=DIV and sets pend<=1.
  - LOAD while pend is already set overwrites div_p; the last value wins and only one ACK follows.
- BUSY = pend, registered.
- Boundary B is defined as st=RUN && Y=0 && cnt==div_q, i.e. the edge at which Y would rise.
- IDLE state:
  - Y held at 0, cnt held at 0.
  - If pend: div_q<=div_p, pend<=0, ACK<=1 on that edge.
  - If EN: st<=RUN, Y<=1, cnt<=0. EN and pend may both be acted on in the same edge; the new div_q governs the first high phase.
- RUN state, off boundary B:
  - If cnt==div_q: cnt<=0, Y<=~Y.
  - Otherwise: cnt<=cnt+1.
- RUN state, at boundary B, in priority order:
  - The pending ratio is applied first (div_q<=div_p, pend<=0, ACK<=1).
  - If EN=0: st<=IDLE and Y stays 0.
  - Otherwise: Y<=1, cnt<=0, and the next high phase uses the new div_q.
- Pulse-width guarantees:
  - Every high phase and every low phase lasts exactly div_q+1 cycles of the ratio active during that phase.
  - A ratio change never alters a phase already in progress.
- EN deassertion never truncates a phase. Y completes its current high phase (if any) and the following low phase, then parks at 0.
- LOAD in the same cycle as boundary B: the new DIV is captured into div_p but is not applied at that boundary; the old div_p (if pend) is applied. The new value is applied at the next boundary B.
- Arithmetic: cnt compares only against div_q and never exceeds div_q, so no wrap occurs. DIV = 2^WIDTH-1 gives a half-period of 2^WIDTH cycles.

## Timing
- Latencies:
  - EN sampled high in IDLE: Y=1 after that same edge, i.e. 1 cycle.
  - LOAD while IDLE: ACK and BUSY falling occur 1 cycle after the LOAD edge capture, i.e. ACK high in cycle t+2 relative to LOAD in cycle t.
  - LOAD while RUN: ACK at the next boundary B. Worst case is 2*(div_q+1)+1 cycles.
  - EN low to IDLE: worst case 2*(div_q+1) cycles; Y is low throughout the final low phase.
- ACK is exactly 1 cycle wide. BUSY falls on the same edge that ACK rises.
- Asynchronous R forces Y=0 immediately. A runt high pulse on Y during reset is accepted and is the only permitted runt case.
- Reset release takes effect at the first CLK edge with R=0, which sees IDLE.

## Test plan
- Reset, then EN=1 with default ratio: Y toggles every cycle, period 2. Reset R=1 mid-high forces Y=0 asynchronously and ACK=0.
- LOAD with DIV=3 while IDLE: BUSY=1 for 1 cycle, then ACK pulse. Then EN=1 gives Y high for 4 cycles, low for 4, period 8.
- Running at DIV=3, LOAD DIV=1 mid high phase: current high and low phases stay at 4 cycles. ACK is at the rising boundary, and the period is 4 from then on.
- Two LOADs (DIV=5, then DIV=2) before the boundary: a single ACK, and the resulting period is 6.
- EN dropped 1 cycle into a high phase at DIV=2: Y completes 3 high and 3 low cycles, then stays 0 and st=IDLE. Re-asserting EN gives Y=1 after 1 edge.
- DIV=15 with WIDTH=4: period 32, with no counter wrap or glitch over 10 periods. Check that every pulse on Y is ≥ div_q+1 cycles.
